// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;

    logic             pc_en;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal_op;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
               retired, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op,
               retired, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, and counts retired instructions.
//
// state      | meaning
// FETCH      | read instruction at PC, PC+4 on mem_ready
// DECODE     | read registers, precompute branch target, dispatch on opcode
// MEM_ADDR   | effective address for lw/sw
// MEM_RD     | data read, wait for mem_ready
// LW_WB      | MDR -> rt
// MEM_WR     | data write, wait for mem_ready
// R_EXEC     | funct-decoded ALU op on A,B
// R_WB       | ALUOut -> rd
// BRANCH     | compare A,B; load branch target if zero
// JUMP       | load jump target
// ADDI_EXEC  | A + sign-extended immediate
// ADDI_WB    | ALUOut -> rt
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input logic                  clk,
    input logic                  reset,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_LW_WB     = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           state_q;
    state_t           next_state;
    logic [CNT_W-1:0] retired_q;

    logic       pc_write, pc_write_cond, retire;
    logic       iord_c, mem_read_c, mem_write_c, ir_write_c, reg_dst_c;
    logic       mem_to_reg_c, reg_write_c, alu_src_a_c, illegal_c;
    logic [1:0] alu_src_b_c, alu_op_c, pc_source_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= next_state;
            if (retire)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        next_state    = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        retire        = 1'b0;
        iord_c        = 1'b0;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        reg_dst_c     = 1'b0;
        mem_to_reg_c  = 1'b0;
        reg_write_c   = 1'b0;
        alu_src_a_c   = 1'b0;
        illegal_c     = 1'b0;
        alu_src_b_c   = 2'b00;
        alu_op_c      = 2'b00;
        pc_source_c   = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = bus.mem_ready;
                pc_write    = bus.mem_ready;
                if (bus.mem_ready)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:     next_state = S_R_EXEC;
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDI_EXEC;
                    default: begin
                        next_state = S_FETCH;
                        illegal_c  = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                next_state  = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                if (bus.mem_ready)
                    next_state = S_LW_WB;
            end
            S_LW_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                retire       = 1'b1;
                next_state   = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                if (bus.mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
                next_state  = S_R_WB;
            end
            S_R_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c   = 1'b1;
                alu_op_c      = 2'b01;
                pc_write_cond = 1'b1;
                pc_source_c   = 2'b01;
                retire        = 1'b1;
                next_state    = S_FETCH;
            end
            S_JUMP: begin
                pc_write    = 1'b1;
                pc_source_c = 2'b10;
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                next_state  = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase

        // Reset silences every strobe so an abandoned instruction never writes.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord_c        = 1'b0;
            mem_read_c    = 1'b0;
            mem_write_c   = 1'b0;
            ir_write_c    = 1'b0;
            reg_dst_c     = 1'b0;
            mem_to_reg_c  = 1'b0;
            reg_write_c   = 1'b0;
            alu_src_a_c   = 1'b0;
            illegal_c     = 1'b0;
            alu_src_b_c   = 2'b00;
            alu_op_c      = 2'b00;
            pc_source_c   = 2'b00;
        end
    end

    assign bus.pc_en      = pc_write | (pc_write_cond & bus.zero);
    assign bus.iord       = iord_c;
    assign bus.mem_read   = mem_read_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.ir_write   = ir_write_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.reg_write  = reg_write_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.pc_source  = pc_source_c;
    assign bus.illegal_op = illegal_c;
    assign bus.retired    = retired_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl; a second instance with a 4-bit
// counter runs the same stimulus to exercise counter wrap.
module tb_mips_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mon_en = 1'b0;
    int         n_pass = 0;
    int         n_fail = 0;

    mips_multicycle_ctrl_if #(.CNT_W(32)) bus ();
    mips_multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus.opcode     = opcode;
    assign bus.zero       = zero;
    assign bus.mem_ready  = mem_ready;
    assign bus4.opcode    = opcode;
    assign bus4.zero      = zero;
    assign bus4.mem_ready = mem_ready;

    mips_multicycle_ctrl #(.CNT_W(32)) u_dut (.clk(clk), .reset(reset), .bus(bus));
    mips_multicycle_ctrl #(.CNT_W(4))  u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk)
        if (mon_en)
            chk("pc_source_never_11", 32'(bus.pc_source == 2'b11), 32'd0);

    initial begin
        reset     = 1'b1;
        opcode    = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) clk1();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_retired", bus.retired, 32'd0);
        chk("rst_mem_read_forced", 32'(bus.mem_read), 32'd0);
        chk("rst_pc_en_forced", 32'(bus.pc_en), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("fetch_mem_read", 32'(bus.mem_read), 32'd1);
        chk("fetch_ir_write", 32'(bus.ir_write), 32'd1);
        chk("fetch_pc_en", 32'(bus.pc_en), 32'd1);
        chk("fetch_alu_src_b", 32'(bus.alu_src_b), 32'd1);

        // FETCH stall
        mem_ready = 1'b0;
        #1;
        chk("stall_ir_write", 32'(bus.ir_write), 32'd0);
        chk("stall_pc_en", 32'(bus.pc_en), 32'd0);
        clk1();
        chk("stall_state", 32'(bus.state), 32'd0);
        mem_ready = 1'b1;

        // R-type: 0,1,6,7,0
        opcode = 6'b000000;
        clk1();
        chk("r_decode_state", 32'(bus.state), 32'd1);
        chk("r_decode_alu_src_b", 32'(bus.alu_src_b), 32'd3);
        chk("r_decode_reg_write", 32'(bus.reg_write), 32'd0);
        clk1();
        chk("r_exec_state", 32'(bus.state), 32'd6);
        chk("r_exec_alu_op", 32'(bus.alu_op), 32'd2);
        chk("r_exec_alu_src_a", 32'(bus.alu_src_a), 32'd1);
        chk("r_exec_reg_write", 32'(bus.reg_write), 32'd0);
        clk1();
        chk("r_wb_state", 32'(bus.state), 32'd7);
        chk("r_wb_reg_write", 32'(bus.reg_write), 32'd1);
        chk("r_wb_reg_dst", 32'(bus.reg_dst), 32'd1);
        chk("r_wb_retired_before", bus.retired, 32'd0);
        clk1();
        chk("r_done_state", 32'(bus.state), 32'd0);
        chk("r_done_retired", bus.retired, 32'd1);

        // lw with two wait cycles in MEM_RD
        opcode = 6'b100011;
        clk1();
        chk("lw_decode_state", 32'(bus.state), 32'd1);
        clk1();
        chk("lw_addr_state", 32'(bus.state), 32'd2);
        chk("lw_addr_alu_src_b", 32'(bus.alu_src_b), 32'd2);
        mem_ready = 1'b0;
        clk1();
        chk("lw_rd_state_1", 32'(bus.state), 32'd3);
        chk("lw_rd_iord", 32'(bus.iord), 32'd1);
        chk("lw_rd_mem_read", 32'(bus.mem_read), 32'd1);
        clk1();
        chk("lw_rd_state_2", 32'(bus.state), 32'd3);
        clk1();
        chk("lw_rd_state_3", 32'(bus.state), 32'd3);
        mem_ready = 1'b1;
        clk1();
        chk("lw_wb_state", 32'(bus.state), 32'd4);
        chk("lw_wb_mem_to_reg", 32'(bus.mem_to_reg), 32'd1);
        chk("lw_wb_reg_write", 32'(bus.reg_write), 32'd1);
        chk("lw_wb_reg_dst", 32'(bus.reg_dst), 32'd0);
        clk1();
        chk("lw_done_state", 32'(bus.state), 32'd0);
        chk("lw_done_retired", bus.retired, 32'd2);

        // sw with one wait cycle in MEM_WR
        opcode = 6'b101011;
        clk1();
        clk1();
        chk("sw_addr_state", 32'(bus.state), 32'd2);
        mem_ready = 1'b0;
        clk1();
        chk("sw_wr_state", 32'(bus.state), 32'd5);
        chk("sw_wr_mem_write", 32'(bus.mem_write), 32'd1);
        chk("sw_wr_mem_read", 32'(bus.mem_read), 32'd0);
        clk1();
        chk("sw_wr_hold_state", 32'(bus.state), 32'd5);
        chk("sw_wr_hold_retired", bus.retired, 32'd2);
        mem_ready = 1'b1;
        clk1();
        chk("sw_done_state", 32'(bus.state), 32'd0);
        chk("sw_done_retired", bus.retired, 32'd3);

        // beq taken
        opcode = 6'b000100;
        zero   = 1'b1;
        clk1();
        clk1();
        chk("beq_t_state", 32'(bus.state), 32'd8);
        chk("beq_t_pc_en", 32'(bus.pc_en), 32'd1);
        chk("beq_t_pc_source", 32'(bus.pc_source), 32'd1);
        chk("beq_t_alu_op", 32'(bus.alu_op), 32'd1);
        clk1();
        chk("beq_t_retired", bus.retired, 32'd4);

        // beq not taken
        zero = 1'b0;
        clk1();
        clk1();
        chk("beq_nt_state", 32'(bus.state), 32'd8);
        chk("beq_nt_pc_en", 32'(bus.pc_en), 32'd0);
        clk1();
        chk("beq_nt_state_after", 32'(bus.state), 32'd0);
        chk("beq_nt_retired", bus.retired, 32'd5);

        // j
        opcode = 6'b000010;
        clk1();
        clk1();
        chk("j_state", 32'(bus.state), 32'd9);
        chk("j_pc_en", 32'(bus.pc_en), 32'd1);
        chk("j_pc_source", 32'(bus.pc_source), 32'd2);
        clk1();
        chk("j_retired", bus.retired, 32'd6);

        // illegal opcode
        opcode = 6'b111111;
        clk1();
        chk("ill_state", 32'(bus.state), 32'd1);
        chk("ill_flag", 32'(bus.illegal_op), 32'd1);
        clk1();
        chk("ill_next_state", 32'(bus.state), 32'd0);
        chk("ill_flag_drop", 32'(bus.illegal_op), 32'd0);
        chk("ill_retired", bus.retired, 32'd6);

        // reset held 3 cycles mid-R_EXEC
        opcode = 6'b000000;
        clk1();
        clk1();
        chk("rr_exec_state", 32'(bus.state), 32'd6);
        reset = 1'b1;
        #1;
        chk("rr_alu_src_a_forced", 32'(bus.alu_src_a), 32'd0);
        chk("rr_alu_op_forced", 32'(bus.alu_op), 32'd0);
        for (int i = 0; i < 3; i++) begin
            clk1();
            chk("rr_state", 32'(bus.state), 32'd0);
            chk("rr_reg_write", 32'(bus.reg_write), 32'd0);
        end
        chk("rr_retired", bus.retired, 32'd0);
        reset = 1'b0;
        #1;
        chk("rr_release_mem_read", 32'(bus.mem_read), 32'd1);

        // 16 addi instructions: the 4-bit counter wraps to 0
        opcode = 6'b001000;
        for (int n = 0; n < 16; n++) begin
            clk1();
            clk1();
            if (n == 0) begin
                chk("addi_exec_state", 32'(bus.state), 32'd10);
                chk("addi_exec_alu_src_b", 32'(bus.alu_src_b), 32'd2);
            end
            clk1();
            if (n == 0) begin
                chk("addi_wb_state", 32'(bus.state), 32'd11);
                chk("addi_wb_reg_write", 32'(bus.reg_write), 32'd1);
                chk("addi_wb_reg_dst", 32'(bus.reg_dst), 32'd0);
            end
            clk1();
            if (n == 14)
                chk("addi_w4_at_15", 32'(bus4.retired), 32'd15);
        end
        chk("addi_retired32", bus.retired, 32'd16);
        chk("addi_retired4_wrap", 32'(bus4.retired), 32'd0);
        chk("addi_final_state", 32'(bus.state), 32'd0);

        mon_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
